// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA transfer statistics block.
// Holds the FSM state encoding, the read-select map and the default block identifier.
package dma_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_e;

    localparam logic [2:0] RD_LAST    = 3'd0;
    localparam logic [2:0] RD_XFER    = 3'd1;
    localparam logic [2:0] RD_TMO     = 3'd2;
    localparam logic [2:0] RD_RESTART = 3'd3;
    localparam logic [2:0] RD_MIN     = 3'd4;
    localparam logic [2:0] RD_MAX     = 3'd5;
    localparam logic [2:0] RD_STATUS  = 3'd6;
    localparam logic [2:0] RD_ID      = 3'd7;

    localparam logic [31:0] BLOCK_ID_DEFAULT = 32'hD3A50001;

endpackage

// File: rtl/dma_edge_det.sv
// One-stage edge detector; rise/fall are combinational against the registered level.
// The register tracks the input even in reset, so a level already high out of reset is not a rise.
module dma_edge_det (
    input  logic clk_i,
    input  logic x_i,
    output logic rise_o,
    output logic fall_o
);

    logic x_q;

    always_ff @(posedge clk_i) begin
        x_q <= x_i;
    end

    assign rise_o = x_i & ~x_q;
    assign fall_o = ~x_i & x_q;

endmodule

// File: rtl/dma_xfer_stats.sv
// Measures DMA transfers in clk_i cycles, classifies done/timeout, keeps counters, registered read port.
// Done/timeout pulse 2 cycles after busy_i falls; min/max duration tracking only with DMA_XFER_MINMAX_EN.
module dma_xfer_stats
    import dma_pkg::*;
#(
    parameter int          DUR_W    = 32,
    parameter int          EVT_W    = 16,
    parameter logic [31:0] BLOCK_ID = BLOCK_ID_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_pulse_i,
    input  logic        end_pulse_i,
    input  logic        busy_i,
    input  logic        clr_i,
    input  logic        rd_req_i,
    input  logic [2:0]  rd_sel_i,
    output logic        rd_ack_o,
    output logic [31:0] rd_data_o,
    output logic        active_o,
    output logic        xfer_done_o,
    output logic        xfer_timeout_o
);

    logic rise_start, rise_end, rise_busy, fall_busy;
    logic fall_start_unused, fall_end_unused, rise_busy_unused_dummy_unused;

    dma_edge_det u_start (.clk_i(clk_i), .x_i(start_pulse_i), .rise_o(rise_start), .fall_o(fall_start_unused));
    dma_edge_det u_end   (.clk_i(clk_i), .x_i(end_pulse_i),   .rise_o(rise_end),   .fall_o(fall_end_unused));
    dma_edge_det u_busy  (.clk_i(clk_i), .x_i(busy_i),        .rise_o(rise_busy),  .fall_o(fall_busy));
    assign rise_busy_unused_dummy_unused = 1'b0;

    state_e             state_q, state_d;
    logic [DUR_W-1:0]   dur_q, dur_d, last_dur_q;
    logic               end_seen_q, end_seen_d;
    logic               restart, commit;
    logic [EVT_W-1:0]   xfer_cnt_q, tmo_cnt_q, restart_cnt_q;
    logic               done_q, tmo_q, ack_q;
    logic [31:0]        data_q, rd_mux;
`ifdef DMA_XFER_MINMAX_EN
    logic [DUR_W-1:0]   min_dur_q, max_dur_q;
`endif

    always_comb begin
        state_d    = state_q;
        dur_d      = dur_q;
        end_seen_d = end_seen_q;
        restart    = 1'b0;
        commit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise_busy) begin
                    state_d    = RUN;
                    dur_d      = DUR_W'(1);
                    end_seen_d = 1'b0;
                end
            end
            RUN: begin
                // The falling cycle is not part of the window, so dur holds there.
                if (fall_busy) begin
                    state_d = COMMIT;
                end else if (dur_q != '1) begin
                    dur_d = dur_q + DUR_W'(1);
                end
                if (rise_start) begin
                    restart    = 1'b1;
                    dur_d      = DUR_W'(1);
                    end_seen_d = 1'b0;
                end
                if (rise_end) begin
                    end_seen_d = 1'b1;
                end
            end
            COMMIT: begin
                commit = 1'b1;
                if (rise_busy) begin
                    state_d    = RUN;
                    dur_d      = DUR_W'(1);
                    end_seen_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            dur_q      <= '0;
            end_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_q      <= dur_d;
            end_seen_q <= end_seen_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            last_dur_q    <= '0;
            xfer_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            restart_cnt_q <= '0;
`ifdef DMA_XFER_MINMAX_EN
            min_dur_q     <= '1;
            max_dur_q     <= '0;
`endif
        end else begin
            if (restart) begin
                restart_cnt_q <= restart_cnt_q + EVT_W'(1);
            end
            if (commit) begin
                last_dur_q <= dur_q;
                if (end_seen_q) begin
                    xfer_cnt_q <= xfer_cnt_q + EVT_W'(1);
`ifdef DMA_XFER_MINMAX_EN
                    if (dur_q < min_dur_q) min_dur_q <= dur_q;
                    if (dur_q > max_dur_q) max_dur_q <= dur_q;
`endif
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + EVT_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel_i)
            RD_LAST:    rd_mux = 32'(last_dur_q);
            RD_XFER:    rd_mux = 32'(xfer_cnt_q);
            RD_TMO:     rd_mux = 32'(tmo_cnt_q);
            RD_RESTART: rd_mux = 32'(restart_cnt_q);
`ifdef DMA_XFER_MINMAX_EN
            RD_MIN:     rd_mux = 32'(min_dur_q);
            RD_MAX:     rd_mux = 32'(max_dur_q);
`else
            RD_MIN:     rd_mux = '0;
            RD_MAX:     rd_mux = '0;
`endif
            RD_STATUS:  rd_mux = {29'b0, end_seen_q, state_q};
            RD_ID:      rd_mux = BLOCK_ID;
            default:    rd_mux = '0;
        endcase
    end

    // Pulses fire even when clr_i suppresses the counter update in COMMIT.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            ack_q  <= 1'b0;
            data_q <= '0;
        end else begin
            done_q <= commit & end_seen_q;
            tmo_q  <= commit & ~end_seen_q;
            ack_q  <= rd_req_i;
            if (rd_req_i) begin
                data_q <= rd_mux;
            end
        end
    end

    assign rd_ack_o       = ack_q;
    assign rd_data_o      = data_q;
    assign active_o       = (state_q == RUN);
    assign xfer_done_o    = done_q;
    assign xfer_timeout_o = tmo_q;

endmodule

// File: tb/tb_dma_xfer_stats.sv
// Scoreboard bench for dma_xfer_stats (DUR_W=8): stimulus pushes expected reads/pulses, a negedge monitor pops and compares.
module tb_dma_xfer_stats;

    logic        clk = 1'b0;
    logic        reset, start_p, end_p, busy, clr, rd_req;
    logic [2:0]  rd_sel;
    logic        rd_ack, active, done, tmo;
    logic [31:0] rd_data;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    typedef struct { logic [2:0] sel; logic [31:0] exp; } rd_t;
    typedef struct { logic is_done; int cyc; } ev_t;
    rd_t rdq[$];
    ev_t evq[$];
    rd_t r_pop;
    ev_t e_pop;

`ifdef DMA_XFER_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dma_xfer_stats #(.DUR_W(8)) dut (
        .clk_i(clk), .reset_i(reset), .start_pulse_i(start_p), .end_pulse_i(end_p),
        .busy_i(busy), .clr_i(clr), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
        .rd_ack_o(rd_ack), .rd_data_o(rd_data), .active_o(active),
        .xfer_done_o(done), .xfer_timeout_o(tmo)
    );

    always @(negedge clk) begin
        if (rd_ack) begin
            vecs++;
            if (rdq.size() == 0) begin
                errs++;
                $display("FAIL rd_unexpected got %h", rd_data);
            end else begin
                r_pop = rdq.pop_front();
                if (rd_data !== r_pop.exp) begin
                    errs++;
                    $display("FAIL rd_sel%0d got %h exp %h", r_pop.sel, rd_data, r_pop.exp);
                end
            end
        end
        if (done || tmo) begin
            vecs++;
            if (evq.size() == 0) begin
                errs++;
                $display("FAIL pulse_unexpected done=%b timeout=%b cyc=%0d", done, tmo, cyc);
            end else begin
                e_pop = evq.pop_front();
                if (done !== e_pop.is_done || tmo !== !e_pop.is_done || cyc != e_pop.cyc) begin
                    errs++;
                    $display("FAIL pulse got done=%b timeout=%b cyc=%0d exp done=%b cyc=%0d",
                             done, tmo, cyc, e_pop.is_done, e_pop.cyc);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got %h exp %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] s, input logic [31:0] e);
        rd_sel = s;
        rd_req = 1'b1;
        rdq.push_back('{sel: s, exp: e});
        tick;
        rd_req = 1'b0;
    endtask

    // mode 0: plain; 1: clr + read sel1 in COMMIT (expects old); 2: busy re-rises in COMMIT
    task automatic xfer(input int n, input int end_at, input int rs_at, input int mode, input logic [31:0] old);
        for (int k = 1; k <= n; k++) begin
            busy    = 1'b1;
            start_p = (k == 1) || (k == rs_at);
            end_p   = (end_at != 0) && (k >= end_at);
            tick;
        end
        busy = 1'b0; start_p = 1'b0; end_p = 1'b0;
        evq.push_back('{is_done: (end_at != 0) && (end_at > rs_at), cyc: cyc + 2});
        tick;
        if (mode == 1) begin
            clr = 1'b1; rd_req = 1'b1; rd_sel = 3'd1;
            rdq.push_back('{sel: 3'd1, exp: old});
            tick;
            clr = 1'b0; rd_req = 1'b0;
        end
        if (mode == 2) begin
            busy = 1'b1; start_p = 1'b1;
            tick;
            chk("active_after_commit_rise", {31'b0, active}, 32'd1);
        end else begin
            repeat (3) tick;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_p = 1'b0; end_p = 1'b0; busy = 1'b0;
        clr = 1'b0; rd_req = 1'b0; rd_sel = 3'd0;
        repeat (3) tick;
        chk("reset_active",  {31'b0, active}, 32'd0);
        chk("reset_done",    {31'b0, done},   32'd0);
        chk("reset_timeout", {31'b0, tmo},    32'd0);
        chk("reset_ack",     {31'b0, rd_ack}, 32'd0);
        chk("reset_data",    rd_data,         32'd0);
        reset = 1'b0;
        tick;
        rd(0, 0); rd(1, 0); rd(2, 0); rd(3, 0);
        rd(4, MM ? 32'hFF : 32'd0); rd(5, 0); rd(6, 0); rd(7, 32'hD3A50001);

        // completed transfer
        xfer(43, 41, 0, 0, 0);
        rd(0, 43); rd(1, 1); rd(2, 0);
        // timeout
        xfer(100, 0, 0, 0, 0);
        rd(2, 1); rd(0, 100); rd(1, 1);
        // restart mid-run
        xfer(32, 30, 20, 0, 0);
        rd(3, 1); rd(0, 13); rd(1, 2);
        // saturation at 8 bits
        xfer(300, 0, 0, 0, 0);
        rd(0, 255); rd(2, 2);
        rd(4, MM ? 32'd13 : 32'd0); rd(5, MM ? 32'd43 : 32'd0);

        clr = 1'b1; tick; clr = 1'b0;
        rd(1, 0); rd(2, 0); rd(3, 0); rd(0, 0);
        rd(4, MM ? 32'hFF : 32'd0); rd(5, 0);
        xfer(50, 45, 0, 0, 0);
        xfer(20, 10, 0, 0, 0);
        rd(4, MM ? 32'd20 : 32'd0); rd(5, MM ? 32'd50 : 32'd0); rd(1, 2); rd(0, 20);

        // clr lands in COMMIT
        xfer(10, 5, 0, 1, 2);
        rd(1, 0); rd(0, 0); rd(3, 0);
        // timeouts leave min/max alone
        xfer(30, 0, 0, 0, 0);
        rd(2, 1); rd(4, MM ? 32'hFF : 32'd0); rd(5, 0); rd(0, 30);

        // status during RUN, then reset mid-run
        busy = 1'b1; start_p = 1'b1; tick; start_p = 1'b0;
        repeat (5) tick;
        rd(6, 32'h1);
        end_p = 1'b1; tick;
        rd(6, 32'h5);
        reset = 1'b1; tick; tick;
        chk("midrun_reset_active", {31'b0, active}, 32'd0);
        reset = 1'b0; end_p = 1'b0; tick;
        rd(1, 0); rd(2, 0); rd(3, 0); rd(6, 0);
        repeat (20) tick;
        chk("busy_held_after_reset_active", {31'b0, active}, 32'd0);
        busy = 1'b0;
        repeat (5) tick;
        chk("after_reset_idle_active", {31'b0, active}, 32'd0);

        // busy re-rises during COMMIT: second transfer must be measured
        xfer(12, 6, 0, 2, 0);
        for (int k = 2; k <= 15; k++) begin
            start_p = 1'b0;
            end_p   = (k >= 8);
            tick;
        end
        busy = 1'b0; end_p = 1'b0;
        evq.push_back('{is_done: 1'b1, cyc: cyc + 2});
        tick;
        repeat (3) tick;
        rd(0, 15); rd(1, 2); rd(2, 0);

        repeat (3) tick;
        for (int w = 0; w < 50 && (rdq.size() != 0 || evq.size() != 0); w++) tick;
        if (rdq.size() != 0 || evq.size() != 0) begin
            vecs++;
            errs++;
            $display("FAIL drain got %0d reads %0d pulses outstanding exp 0", rdq.size(), evq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
